// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: one MEM-stage op at a time onto a word-aligned byte-lane bus,
// with a timeout that turns a hung memory into an error. Define LSU_MISALIGN_TRAP_EN to trap misaligned ops.
module lsu_mem_initiator #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic            clk,
  input  logic            rstn,
  // core side: an op transfers on the rising edge where req_valid && req_ready;
  // req_ready is high only while idle, so at most one op is ever in flight
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic            resp_err,
  output logic [XLEN-1:0] resp_rdata,
  // memory side
  output logic            mem_req,
  output logic            mem_we,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  // debug view of the FSM: 0=IDLE 1=REQ 2=WAIT 3=RESP
  output logic [1:0]      dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              accept;
  logic              timeout;
  logic              mis_n;
  logic [1:0]        size_n;
  logic [XLEN-1:0]   addr_n;
  logic [1:0]        lane;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   load_ext;
  logic [3:0]        be;
  logic [XLEN-1:0]   wdata_lane;

  assign accept  = req_valid && (state_q == IDLE);
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign lane    = addr_q[1:0];

  // Normalise the incoming op: either flag it as misaligned or force it aligned.
  always_comb begin
    size_n = req_size;
    addr_n = req_addr;
    mis_n  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    case (req_size)
      2'b01:   mis_n = req_addr[0];
      2'b10:   mis_n = |req_addr[1:0];
      2'b11:   mis_n = 1'b1;
      default: mis_n = 1'b0;
    endcase
`else
    if (req_size == 2'b11) size_n = 2'b10;
    if (size_n == 2'b01)      addr_n[0]   = 1'b0;
    else if (size_n == 2'b10) addr_n[1:0] = 2'b00;
`endif
  end

  always_comb begin
    case (size_q)
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = 4'b0011 << lane;
      default: be = 4'b1111;
    endcase
  end

  always_comb begin
    case (size_q)
      2'b00:   wdata_lane = {(XLEN/8){wdata_q[7:0]}};
      2'b01:   wdata_lane = {(XLEN/16){wdata_q[15:0]}};
      default: wdata_lane = wdata_q;
    endcase
  end

  assign shifted = mem_rdata >> {lane, 3'b000};

  always_comb begin
    case (size_q)
      2'b00:   load_ext = {{(XLEN-8){shifted[7] & ~uns_q}}, shifted[7:0]};
      2'b01:   load_ext = {{(XLEN-16){shifted[15] & ~uns_q}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = mis_n ? RESP : REQ;
      REQ: begin
        if (timeout)      state_d = RESP;
        else if (mem_gnt) state_d = WAIT;
      end
      // data that arrives on the last allowed cycle still wins over the timeout
      WAIT: begin
        if (mem_rvalid)   state_d = RESP;
        else if (timeout) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    req_ready  = (state_q == IDLE);
    mem_req    = (state_q == REQ);
    mem_we     = (state_q == REQ) && we_q;
    mem_be     = (state_q == REQ) ? be : 4'b0000;
    mem_addr   = (state_q == REQ) ? {addr_q[XLEN-1:2], 2'b00} : '0;
    mem_wdata  = (state_q == REQ) ? wdata_lane : '0;
    resp_valid = (state_q == RESP);
    resp_err   = (state_q == RESP) && err_q;
    resp_rdata = (state_q == RESP) ? rdata_q : '0;
  end

  assign dbg_state_o = state_q;

  // ---------------- op / response datapath ----------------
  always_comb begin
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = req_we;
          size_d  = size_n;
          uns_d   = req_unsigned;
          addr_d  = addr_n;
          wdata_d = req_wdata;
          err_d   = mis_n;
          rdata_d = '0;
          cnt_d   = '0;
        end
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (timeout) err_d = 1'b1;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_rvalid)   rdata_d = we_q ? '0 : load_ext;
        else if (timeout) err_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator: reset, loads/stores across lanes, timeout, misalignment, async abort.
module tb_lsu_mem_initiator;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  dbg_state;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // values observed by do_txn
  logic        o_req, o_we, o_rdy1, o_rdy2, o_rv2, o_rv, o_err, o_rv_after, o_rdy_after;
  logic [3:0]  o_be;
  logic [31:0] o_addr, o_wdata, o_rdata;

  int resp_cyc;
  int req_cnt;

  lsu_mem_initiator #(.XLEN(32), .TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    step();
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
  endtask

  // accept in cycle 0, gnt in cycle 1, rvalid in cycle 2, response expected in cycle 3
  task automatic do_txn(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd);
    drive_req(we, size, uns, addr, wd);
    o_req = mem_req; o_we = mem_we; o_be = mem_be; o_addr = mem_addr;
    o_wdata = mem_wdata; o_rdy1 = req_ready;
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rd;
    o_rdy2 = req_ready; o_rv2 = resp_valid;
    step();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    o_rv = resp_valid; o_err = resp_err; o_rdata = resp_rdata;
    step();
    o_rv_after = resp_valid; o_rdy_after = req_ready;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rstn = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #2;
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_mem_be", {28'h0, mem_be}, 32'h0);
    check("rst_state", {30'h0, dbg_state}, 32'h0);
    step();
    rstn = 1'b1;
    step();

    // SW 0xDEADBEEF @0x100
    do_txn(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0);
    check("sw_mem_req", {31'h0, o_req}, 32'h1);
    check("sw_mem_we", {31'h0, o_we}, 32'h1);
    check("sw_be", {28'h0, o_be}, 32'hF);
    check("sw_addr", o_addr, 32'h100);
    check("sw_wdata", o_wdata, 32'hDEADBEEF);
    check("sw_early_resp", {31'h0, o_rv2}, 32'h0);
    check("sw_resp_valid", {31'h0, o_rv}, 32'h1);
    check("sw_resp_err", {31'h0, o_err}, 32'h0);
    check("sw_rdata", o_rdata, 32'h0);
    check("sw_resp_pulse", {31'h0, o_rv_after}, 32'h0);
    check("sw_ready_after", {31'h0, o_rdy_after}, 32'h1);

    // LB signed / LBU @0x103
    do_txn(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80000000);
    check("lb_be", {28'h0, o_be}, 32'h8);
    check("lb_addr", o_addr, 32'h100);
    check("lb_we", {31'h0, o_we}, 32'h0);
    check("lb_rdata", o_rdata, 32'hFFFFFF80);
    do_txn(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80000000);
    check("lbu_rdata", o_rdata, 32'h00000080);

    // LB signed @0x101, positive byte
    do_txn(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 32'h00007F00);
    check("lb1_be", {28'h0, o_be}, 32'h2);
    check("lb1_rdata", o_rdata, 32'h0000007F);

    // SH 0x1234 @0x102
    do_txn(1'b1, 2'b01, 1'b0, 32'h102, 32'h00001234, 32'h0);
    check("sh_addr", o_addr, 32'h100);
    check("sh_be", {28'h0, o_be}, 32'hC);
    check("sh_wdata", o_wdata, 32'h12341234);
    check("sh_ready_req", {31'h0, o_rdy1}, 32'h0);
    check("sh_ready_wait", {31'h0, o_rdy2}, 32'h0);
    check("sh_resp_valid", {31'h0, o_rv}, 32'h1);

    // SB 0xAB @0x101
    do_txn(1'b1, 2'b00, 1'b0, 32'h101, 32'h000000AB, 32'h0);
    check("sb_be", {28'h0, o_be}, 32'h2);
    check("sb_wdata", o_wdata, 32'hABABABAB);

    // LH signed @0x102, LHU @0x100
    do_txn(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'h87654321);
    check("lh_rdata", o_rdata, 32'hFFFF8765);
    do_txn(1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 32'h8765F321);
    check("lhu_be", {28'h0, o_be}, 32'h3);
    check("lhu_rdata", o_rdata, 32'h0000F321);

    // LW @0x104
    do_txn(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 32'hCAFEF00D);
    check("lw_addr", o_addr, 32'h104);
    check("lw_rdata", o_rdata, 32'hCAFEF00D);

    // LW @0x200 with gnt held low: 64 cycles of mem_req, response in cycle 65
    drive_req(1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
    resp_cyc = 0;
    req_cnt  = 0;
    for (int k = 1; k <= 200; k++) begin
      if (resp_valid) begin
        resp_cyc = k;
        break;
      end
      if (mem_req) req_cnt++;
      step();
    end
    check("tmo_resp_cycle", resp_cyc, 32'd65);
    check("tmo_req_cycles", req_cnt, 32'd64);
    check("tmo_err", {31'h0, resp_err}, 32'h1);
    check("tmo_rdata", resp_rdata, 32'h0);
    step();
    check("tmo_mem_req_after", {31'h0, mem_req}, 32'h0);
    check("tmo_ready_after", {31'h0, req_ready}, 32'h1);

`ifdef LSU_MISALIGN_TRAP_EN
    // LH @0x101 traps without a bus access
    drive_req(1'b0, 2'b01, 1'b0, 32'h101, 32'h0);
    check("mis_lh_mem_req", {31'h0, mem_req}, 32'h0);
    check("mis_lh_resp_valid", {31'h0, resp_valid}, 32'h1);
    check("mis_lh_err", {31'h0, resp_err}, 32'h1);
    check("mis_lh_rdata", resp_rdata, 32'h0);
    step();
    check("mis_lh_ready", {31'h0, req_ready}, 32'h1);
    drive_req(1'b0, 2'b11, 1'b0, 32'h100, 32'h0);
    check("mis_size3_err", {31'h0, resp_err}, 32'h1);
    step();
`else
    // LH @0x101 is forced to the aligned half at 0x100
    do_txn(1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 32'h1234BEEF);
    check("mis_lh_addr", o_addr, 32'h100);
    check("mis_lh_be", {28'h0, o_be}, 32'h3);
    check("mis_lh_err", {31'h0, o_err}, 32'h0);
    check("mis_lh_rdata", o_rdata, 32'hFFFFBEEF);
    // size=11 behaves as an aligned word
    do_txn(1'b0, 2'b11, 1'b0, 32'h103, 32'h0, 32'h13579BDF);
    check("sz3_addr", o_addr, 32'h100);
    check("sz3_be", {28'h0, o_be}, 32'hF);
    check("sz3_rdata", o_rdata, 32'h13579BDF);
`endif

    // async reset while in WAIT, then a stray rvalid
    drive_req(1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    check("abort_in_wait", {30'h0, dbg_state}, 32'h2);
    rstn = 1'b0;
    #1;
    check("abort_mem_req", {31'h0, mem_req}, 32'h0);
    check("abort_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("abort_ready", {31'h0, req_ready}, 32'h1);
    step();
    rstn = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h55AA55AA;
    step();
    mem_rvalid = 1'b0;
    mem_rdata = 32'h0;
    check("stray_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("stray_state", {30'h0, dbg_state}, 32'h0);
    step();
    check("stray_resp_valid2", {31'h0, resp_valid}, 32'h0);
    check("stray_ready", {31'h0, req_ready}, 32'h1);

    // a normal op still works after the abort
    do_txn(1'b0, 2'b00, 1'b1, 32'h302, 32'h0, 32'h00C30000);
    check("post_rst_be", {28'h0, o_be}, 32'h4);
    check("post_rst_rdata", o_rdata, 32'h000000C3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
